// File: rtl/multi_tick_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
package multi_tick_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Reset divisor: one tick per second at 100 MHz.
  localparam int unsigned DEFAULT_DIV_VAL = 100_000_000;

  // Channel-index width; never below one bit so N_CH=1 still has a port.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_tick_generator_tick_channel.sv
// One tick channel: divisor, mode, counter, done flag and registered tick.
module tick_channel
  import multi_tick_pkg::*;
#(
  parameter int          COUNT_BIT   = 30,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VAL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  input  logic                 ld,
  input  logic [COUNT_BIT-1:0] ld_div,
  input  logic                 ld_oneshot,
  output logic                 tick,
  output logic                 busy
);

  localparam logic [COUNT_BIT-1:0] DIV_RST = COUNT_BIT'(DEFAULT_DIV);

  logic [COUNT_BIT-1:0] div;
  logic [COUNT_BIT-1:0] cnt;
  logic                 oneshot;
  logic                 done;
  logic                 adv;

  // D=0 is excluded here, so div-1 below can never wrap.
  assign adv  = step && (div != '0) && !done;
  assign busy = (div != '0) && !done;

  // Counter/tick update; a load beats a coincident terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= DIV_RST;
      oneshot <= MODE_PERIODIC;
      cnt     <= '0;
      done    <= 1'b0;
      tick    <= 1'b0;
    end else if (ld) begin
      div     <= ld_div;
      oneshot <= ld_oneshot;
      cnt     <= '0;
      done    <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (adv) begin
        if (cnt == div - COUNT_BIT'(1)) begin
          cnt  <= '0;
          tick <= 1'b1;
          if (oneshot == MODE_ONESHOT) done <= 1'b1;
        end else begin
          cnt <= cnt + COUNT_BIT'(1);
        end
      end
    end
  end

endmodule

// File: rtl/multi_tick_generator.sv
// N_CH independent programmable tick channels with a write port.
// Optional macro MULTI_TICK_GEN_CASCADE_EN chains channel k>0 onto the
// tick of channel k-1 (sec/min/hour style).
module multi_tick_generator
  import multi_tick_pkg::*;
#(
  parameter int          N_CH        = 4,
  parameter int          COUNT_BIT   = 30,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VAL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    wr_en,
  input  logic [ch_w(N_CH)-1:0]   wr_ch,
  input  logic [COUNT_BIT-1:0]    wr_div,
  input  logic                    wr_oneshot,
  output logic                    wr_ack,
  output logic                    wr_err,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         busy
);

  localparam int CH_W = ch_w(N_CH);

  logic wr_ok;

  // Widen by one bit so N_CH itself is representable in the compare.
  assign wr_ok = {1'b0, wr_ch} < (CH_W+1)'(N_CH);

  // Write handshake: ack for a valid channel, err otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= wr_en && wr_ok;
      wr_err <= wr_en && !wr_ok;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic step;
    logic ld;

    assign ld = wr_en && wr_ok && (wr_ch == CH_W'(i));

`ifdef MULTI_TICK_GEN_CASCADE_EN
    if (i == 0) begin : g_root
      assign step = en;
    end else begin : g_link
      assign step = en && tick[i-1];
    end
`else
    assign step = en;
`endif

    tick_channel #(
      .COUNT_BIT   (COUNT_BIT),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .step       (step),
      .ld         (ld),
      .ld_div     (wr_div),
      .ld_oneshot (wr_oneshot),
      .tick       (tick[i]),
      .busy       (busy[i])
    );
  end

endmodule
